// File: rtl/sumador_restador_serial_if.sv
// ---------------------------------------------------------------------------
// sumador_restador_serial_if
// Handshake and data bundle for the digit-serial adder/subtractor.
//   start  : request a new operation (sampled only when the unit is not busy)
//   A, B   : operands, captured on the accepting edge
//   select : 0 = A+B, 1 = A-B, captured on the accepting edge
//   busy   : operation in progress
//   done   : one-cycle pulse, results just updated
//   S      : result modulo 2^WIDTH
//   Cout   : carry out (in subtract mode 1 = no borrow)
//   V      : two's-complement overflow
// The master modport belongs to the requester and the slave modport to the
// arithmetic unit.
// ---------------------------------------------------------------------------
interface sumador_restador_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             select;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             V;

  modport master (
    output start, A, B, select,
    input  busy, done, S, Cout, V
  );

  modport slave (
    input  start, A, B, select,
    output busy, done, S, Cout, V
  );
endinterface

// File: rtl/sumador_restador_serial.sv
// ---------------------------------------------------------------------------
// sumador_restador_serial
// Multi-cycle, digit-serial adder/subtractor. Each operation takes
// N = WIDTH/STEP cycles and handles STEP bits per cycle, starting from the
// least significant digit. Subtraction is done as A + ~B + 1.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, aborts any operation in flight
//   bus  : slave side of sumador_restador_serial_if
//          (start/A/B/select in, busy/done/S/Cout/V out)
// S, Cout and V are held until the next operation completes.
// ---------------------------------------------------------------------------
module sumador_restador_serial #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input logic                    clk,
  input logic                    rst,
  sumador_restador_serial_if.slave bus
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] s_q;
  logic             carry;
  logic             cout_q;
  logic             v_q;
  logic [CW-1:0]    cnt;
  logic [STEP-1:0]  a_dig;
  logic [STEP-1:0]  b_dig;
  logic [STEP:0]    dig_sum;
  logic             v_dig;
  logic             accept;
  logic             last;

  // A new operation is taken in both IDLE and DONE, which allows
  // back-to-back operations without an idle gap.
  assign accept = (state != RUN) && bus.start;
  assign last   = (state == RUN) && (cnt == CW'(N - 1));

  assign a_dig   = a_sr[STEP-1:0];
  assign b_dig   = b_sr[STEP-1:0];
  assign dig_sum = {1'b0, a_dig} + {1'b0, b_dig} + {{STEP{1'b0}}, carry};

  // The new digit enters the result register from the MSB side, so after N
  // digits the least significant digit has reached bit 0.
  assign res_next = WIDTH'({dig_sum[STEP-1:0], res_sr} >> STEP);

  // Sign-rule form of (carry into MSB) xor (carry out of MSB); only
  // meaningful on the last digit, where the digit MSB is the operand MSB.
  assign v_dig = (a_dig[STEP-1] == b_dig[STEP-1]) &&
                 (dig_sum[STEP-1] != a_dig[STEP-1]);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = bus.start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, one digit per RUN cycle, and publication of
  // the result only on the completion edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      v_q    <= 1'b0;
    end else if (accept) begin
      a_sr   <= bus.A;
      b_sr   <= bus.select ? ~bus.B : bus.B;
      res_sr <= '0;
      carry  <= bus.select;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> STEP;
      b_sr   <= b_sr >> STEP;
      res_sr <= res_next;
      carry  <= dig_sum[STEP];
      cnt    <= cnt + CW'(1);
      if (last) begin
        s_q    <= res_next;
        cout_q <= dig_sum[STEP];
        v_q    <= v_dig;
      end
    end
  end

  // busy excludes the first RUN cycle (counter still 0), so it is high for
  // N-1 cycles; start is ignored for the whole RUN state regardless.
  assign bus.busy = (state == RUN) && (cnt != '0);
  assign bus.done = (state == DONE);
  assign bus.S    = s_q;
  assign bus.Cout = cout_q;
  assign bus.V    = v_q;

endmodule

// File: tb/tb_sumador_restador_serial.sv
// ---------------------------------------------------------------------------
// tb_sumador_restador_serial
// Bench for sumador_restador_serial. Three instances share clk/rst:
//   dut 0 : WIDTH=8, STEP=1
//   dut 1 : WIDTH=8, STEP=4
//   dut 2 : WIDTH=4, STEP=2
// Expected results come from signed/unsigned integer arithmetic on the
// operand values.
// ---------------------------------------------------------------------------
module tb_sumador_restador_serial;

  logic clk;
  logic rst;

  int checks;
  int failures;

  logic       start_d [3];
  logic [7:0] a_d     [3];
  logic [7:0] b_d     [3];
  logic       sel_d   [3];

  logic       done_o  [3];
  logic       busy_o  [3];
  logic       cout_o  [3];
  logic       v_o     [3];
  logic [7:0] s_o     [3];

  sumador_restador_serial_if #(.WIDTH(8)) bus0 ();
  sumador_restador_serial_if #(.WIDTH(8)) bus1 ();
  sumador_restador_serial_if #(.WIDTH(4)) bus2 ();

  sumador_restador_serial #(.WIDTH(8), .STEP(1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sumador_restador_serial #(.WIDTH(8), .STEP(4)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  sumador_restador_serial #(.WIDTH(4), .STEP(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus0.start  = start_d[0];
  assign bus0.A      = a_d[0];
  assign bus0.B      = b_d[0];
  assign bus0.select = sel_d[0];
  assign bus1.start  = start_d[1];
  assign bus1.A      = a_d[1];
  assign bus1.B      = b_d[1];
  assign bus1.select = sel_d[1];
  assign bus2.start  = start_d[2];
  assign bus2.A      = a_d[2][3:0];
  assign bus2.B      = b_d[2][3:0];
  assign bus2.select = sel_d[2];

  assign done_o[0] = bus0.done;
  assign busy_o[0] = bus0.busy;
  assign cout_o[0] = bus0.Cout;
  assign v_o[0]    = bus0.V;
  assign s_o[0]    = bus0.S;
  assign done_o[1] = bus1.done;
  assign busy_o[1] = bus1.busy;
  assign cout_o[1] = bus1.Cout;
  assign v_o[1]    = bus1.V;
  assign s_o[1]    = bus1.S;
  assign done_o[2] = bus2.done;
  assign busy_o[2] = bus2.busy;
  assign cout_o[2] = bus2.Cout;
  assign v_o[2]    = bus2.V;
  assign s_o[2]    = {4'b0000, bus2.S};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation timeout");
  end

  function automatic int n_of(input int d);
    return (d == 0) ? 8 : 2;
  endfunction

  function automatic int width_of(input int d);
    return (d == 2) ? 4 : 8;
  endfunction

  // Reference: {Cout, V, S} from integer arithmetic on the operand values.
  function automatic logic [9:0] ref_model(input int w, input int a, input int b, input bit sel);
    int full;
    int half;
    int sa;
    int sb;
    int r;
    int sr;
    logic [7:0] s;
    bit c;
    bit v;
    full = 1 << w;
    half = full / 2;
    sa = (a >= half) ? a - full : a;
    sb = (b >= half) ? b - full : b;
    r = sel ? a - b : a + b;
    s = 8'(((r % full) + full) % full);
    c = sel ? (a >= b) : (a + b >= full);
    sr = sel ? sa - sb : sa + sb;
    v = (sr < -half) || (sr > half - 1);
    return {c, v, s};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int d, input logic [7:0] a, input logic [7:0] b, input logic sel);
    @(negedge clk);
    a_d[d]     = a;
    b_d[d]     = b;
    sel_d[d]   = sel;
    start_d[d] = 1'b1;
  endtask

  // Waits for the accepting edge, then follows the operation to its done
  // pulse. With chain set, start stays high and the operands switch to the
  // next operation right after the accepting edge.
  task automatic complete_op(input int d, input logic [7:0] a, input logic [7:0] b, input logic sel,
                             input string tag, input bit chain,
                             input logic [7:0] na, input logic [7:0] nb, input logic nsel);
    int n;
    int lat;
    int busy_cnt;
    logic [7:0] prev_s;
    bit s_held;
    logic [9:0] exp;
    n = n_of(d);
    @(posedge clk);
    #1;
    if (chain) begin
      a_d[d]   = na;
      b_d[d]   = nb;
      sel_d[d] = nsel;
    end else begin
      start_d[d] = 1'b0;
    end
    prev_s   = s_o[d];
    lat      = -1;
    busy_cnt = 0;
    s_held   = 1'b1;
    for (int c = 0; c <= 4 * n + 4; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (done_o[d]) begin
        lat = c;
        break;
      end
      if (busy_o[d]) busy_cnt++;
      if (s_o[d] !== prev_s) s_held = 1'b0;
    end
    exp = ref_model(width_of(d), int'(a), int'(b), sel);
    check_output({tag, ".latency"}, lat, n);
    check_output({tag, ".busy_cycles"}, busy_cnt, n - 1);
    check_output({tag, ".s_held"}, 32'(s_held), 1);
    check_output({tag, ".busy_at_done"}, 32'(busy_o[d]), 0);
    check_output({tag, ".S"}, 32'(s_o[d]), 32'(exp[7:0]));
    check_output({tag, ".Cout"}, 32'(cout_o[d]), 32'(exp[9]));
    check_output({tag, ".V"}, 32'(v_o[d]), 32'(exp[8]));
    if (!chain) begin
      @(posedge clk);
      #1;
      check_output({tag, ".done_pulse"}, 32'(done_o[d]), 0);
    end
  endtask

  task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b, input logic sel, input string tag);
    apply_stimulus(d, a, b, sel);
    complete_op(d, a, b, sel, tag, 1'b0, 8'd0, 8'd0, 1'b0);
  endtask

  initial begin
    bit seen;
    logic [7:0] ra;
    logic [7:0] rb;
    logic rs;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start_d[d] = 1'b0;
      a_d[d]     = 8'd0;
      b_d[d]     = 8'd0;
      sel_d[d]   = 1'b0;
    end

    // Reset state of all three instances.
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check_output("reset.busy", 32'(busy_o[d]), 0);
      check_output("reset.done", 32'(done_o[d]), 0);
      check_output("reset.S", 32'(s_o[d]), 0);
      check_output("reset.Cout", 32'(cout_o[d]), 0);
      check_output("reset.V", 32'(v_o[d]), 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed additions and subtractions, 8-bit serial.
    run_op(0, 8'd100, 8'd27, 1'b0, "add_100_27");
    run_op(0, 8'd100, 8'd28, 1'b0, "add_100_28");
    run_op(0, 8'd200, 8'd100, 1'b0, "add_200_100");
    run_op(0, 8'd5, 8'd9, 1'b1, "sub_5_9");
    run_op(0, 8'd9, 8'd9, 1'b1, "sub_9_9");
    run_op(0, 8'd128, 8'd1, 1'b1, "sub_128_1");

    // start held through the first operation with new operands, then the
    // DONE-cycle start launches the second one back to back.
    apply_stimulus(0, 8'd50, 8'd20, 1'b1);
    complete_op(0, 8'd50, 8'd20, 1'b1, "hold_first", 1'b1, 8'd77, 8'd200, 1'b0);
    complete_op(0, 8'd77, 8'd200, 1'b0, "b2b_second", 1'b0, 8'd0, 8'd0, 1'b0);

    // Reset during the third RUN cycle aborts the operation.
    apply_stimulus(0, 8'd60, 8'd70, 1'b0);
    @(posedge clk);
    #1;
    start_d[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("abort.busy", 32'(busy_o[0]), 0);
    check_output("abort.done", 32'(done_o[0]), 0);
    check_output("abort.S", 32'(s_o[0]), 0);
    check_output("abort.Cout", 32'(cout_o[0]), 0);
    check_output("abort.V", 32'(v_o[0]), 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (18) begin
      @(posedge clk);
      #1;
      if (done_o[0]) seen = 1'b1;
    end
    check_output("abort.no_done", 32'(seen), 0);

    // Random operations on the 8-bit serial instance.
    repeat (16) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      run_op(0, ra, rb, rs, "rnd_w8s1");
    end

    // 8-bit, 4 bits per cycle.
    run_op(1, 8'd9, 8'd9, 1'b1, "s4_sub_9_9");
    repeat (16) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      run_op(1, ra, rb, rs, "rnd_w8s4");
    end

    // 4-bit, 2 bits per cycle: every operand pair in both modes.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int s = 0; s < 2; s++) begin
          run_op(2, 8'(a), 8'(b), 1'(s), "sweep_w4s2");
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
